// File: rtl/flipflop_bank_multimode.sv
// flipflop_bank_multimode
// A bank of WIDTH flip-flops whose next-state rule (D, T, JK or SR) is chosen
// per edge by 'mode'. The bank also provides registered inverted outputs,
// a one-cycle change pulse, a saturating change counter and a sticky flag
// that records any SR edge where set and reset were requested together.
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.

module flipflop_bank_multimode #(
  parameter int unsigned           WIDTH       = 8,
  parameter int unsigned           CNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 err_clear,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_inverse,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] change_count,
  output logic                 sr_error
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // State registers
  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     q_inv_r;
  logic                 changed_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 sr_error_r;

  // Combinational next-state terms
  logic [WIDTH-1:0]     mode_q_s;
  logic [WIDTH-1:0]     next_q_s;
  logic                 change_s;
  logic                 sr_set_s;

  // Next-state value each flip-flop type would produce from the current q
  always_comb begin
    mode_q_s = q_r;
    case (mode)
      MODE_D:  mode_q_s = a;
      MODE_T:  mode_q_s = q_r ^ a;
      // JK characteristic: q+ = j & ~q | ~k & q (11 toggles)
      MODE_JK: mode_q_s = (a & ~q_r) | (~b & q_r);
      // SR: set when s only, clear when r only, hold on 00 and on 11
      MODE_SR: mode_q_s = (a & ~b) | (q_r & ~(a ^ b));
      default: mode_q_s = q_r;
    endcase
  end

  // Apply clear/enable priority and derive change and SR-violation events
  always_comb begin
    next_q_s = q_r;
    if (clr) begin
      next_q_s = RESET_VALUE;
    end else if (en) begin
      next_q_s = mode_q_s;
    end else begin
      next_q_s = q_r;
    end
    change_s = (next_q_s != q_r);
    sr_set_s = en && !clr && (mode == MODE_SR) && ((a & b) != {WIDTH{1'b0}});
  end

  // Storage, inverted copy, change pulse, saturating counter and sticky flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r        <= RESET_VALUE;
      q_inv_r    <= ~RESET_VALUE;
      changed_r  <= 1'b0;
      count_r    <= {CNT_WIDTH{1'b0}};
      sr_error_r <= 1'b0;
    end else begin
      q_r       <= next_q_s;
      q_inv_r   <= ~next_q_s;
      changed_r <= change_s;
      if (change_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      // A new violation outranks a clear request on the same edge
      if (sr_set_s) begin
        sr_error_r <= 1'b1;
      end else if (err_clear) begin
        sr_error_r <= 1'b0;
      end else begin
        sr_error_r <= sr_error_r;
      end
    end
  end

  assign q            = q_r;
  assign q_inverse    = q_inv_r;
  assign changed      = changed_r;
  assign change_count = count_r;
  assign sr_error     = sr_error_r;

endmodule

// File: tb/tb_flipflop_bank_multimode.sv
// Self-checking bench for flipflop_bank_multimode. A behavioural per-bit
// model tracks the expected state; a second instance with a 3-bit counter
// exercises saturation on the same stimulus.

module tb_flipflop_bank_multimode;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       err_clear;

  logic [7:0] q, q_inverse, change_count;
  logic       changed, sr_error;
  logic [7:0] q3, q_inverse3;
  logic [2:0] change_count3;
  logic       changed3, sr_error3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_q;
  logic       m_chg;
  int         m_cnt;
  int         m_cnt3;
  logic       m_err;

  flipflop_bank_multimode #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a), .b(b),
    .err_clear(err_clear), .q(q), .q_inverse(q_inverse), .changed(changed),
    .change_count(change_count), .sr_error(sr_error)
  );

  flipflop_bank_multimode #(.WIDTH(8), .CNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a), .b(b),
    .err_clear(err_clear), .q(q3), .q_inverse(q_inverse3), .changed(changed3),
    .change_count(change_count3), .sr_error(sr_error3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural next state, evaluated bit by bit from the flip-flop tables
  function automatic logic [7:0] model_next(input logic [7:0] cq, input logic [1:0] md,
                                            input logic [7:0] ia, input logic [7:0] ib,
                                            input logic ien, input logic iclr);
    logic [7:0] n;
    if (iclr) return 8'h00;
    if (!ien) return cq;
    n = cq;
    for (int i = 0; i < 8; i++) begin
      if (md == 2'd0) n[i] = ia[i];
      else if (md == 2'd1) n[i] = ia[i] ? ~cq[i] : cq[i];
      else if (md == 2'd2) begin
        if (ia[i] && ib[i]) n[i] = ~cq[i];
        else if (ia[i])     n[i] = 1'b1;
        else if (ib[i])     n[i] = 1'b0;
        else                n[i] = cq[i];
      end else begin
        if (ia[i] && !ib[i])      n[i] = 1'b1;
        else if (ib[i] && !ia[i]) n[i] = 1'b0;
        else                      n[i] = cq[i];
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_chg = 1'b0; m_cnt = 0; m_cnt3 = 0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".q"},        32'(q),             32'(m_q));
    check_val({tag, ".qinv"},     32'(q_inverse),     32'(8'(~m_q)));
    check_val({tag, ".changed"},  32'(changed),       32'(m_chg));
    check_val({tag, ".count"},    32'(change_count),  32'(m_cnt));
    check_val({tag, ".sr_error"}, 32'(sr_error),      32'(m_err));
    check_val({tag, ".q3"},       32'(q3),            32'(m_q));
    check_val({tag, ".count3"},   32'(change_count3), 32'(m_cnt3));
  endtask

  // One clock edge: predict, wait for the edge, update model, compare
  task automatic step(input string tag);
    logic [7:0] nq;
    logic       set_err;
    nq      = model_next(m_q, mode, a, b, en, clr);
    set_err = en && !clr && (mode == 2'd3) && ((a & b) != 8'h00);
    @(posedge clk);
    #1;
    m_chg = (nq != m_q);
    if (m_chg) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt3 < 7)  m_cnt3++;
    end
    if (set_err) m_err = 1'b1;
    else if (err_clear) m_err = 1'b0;
    m_q = nq;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    en = 1'b0; clr = 1'b0; err_clear = 1'b0;
    rst = 1'b0;
  endtask

  logic [7:0] dseq [4] = '{8'hA5, 8'h5A, 8'h5A, 8'h00};
  logic       cexp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    model_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; err_clear = 1'b0;
    mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    #1;
    check_all("reset0");
    // Reset holds regardless of clock and inputs
    for (int i = 0; i < 3; i++) begin
      mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      #1;
      check_all("reset_clk");
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold_en0");

    // D built from T
    en = 1'b1; mode = 2'd1; b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      a = dseq[i] ^ m_q;
      step("d_via_t");
      check_val("d_via_t.q_exp", 32'(q), 32'(dseq[i]));
      check_val("d_via_t.chg_exp", 32'(changed), 32'(cexp[i]));
    end
    check_val("d_via_t.count3", 32'(change_count), 32'd3);

    // JK then SR with violation
    mode = 2'd0; a = 8'h0F; step("load0F");
    mode = 2'd2; a = 8'hF0; b = 8'h3C; step("jk");
    check_val("jk.q_exp", 32'(q), 32'hF3);
    mode = 2'd3; a = 8'h01; b = 8'h01; step("sr11");
    check_val("sr11.q_exp", 32'(q), 32'hF3);
    check_val("sr11.err_exp", 32'(sr_error), 32'd1);
    err_clear = 1'b1; step("sr_set_wins");
    check_val("sr_set_wins.err_exp", 32'(sr_error), 32'd1);
    a = 8'h00; step("err_clear");
    check_val("err_clear.err_exp", 32'(sr_error), 32'd0);
    err_clear = 1'b0;

    // Clear outranks enable and mode
    mode = 2'd0; a = 8'hFF; clr = 1'b1; step("clr_prio");
    check_val("clr_prio.q_exp", 32'(q), 32'h00);
    step("clr_nochange");
    check_val("clr_nochange.chg_exp", 32'(changed), 32'd0);
    clr = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 15) == 0);
      err_clear = ($urandom_range(0, 3) == 0);
      mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      step("random");
    end

    // Counter saturation on the 3-bit instance
    do_reset();
    en = 1'b1; mode = 2'd1; a = 8'h01; b = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      step("sat");
      check_val("sat.count3_exp", 32'(change_count3), (i < 7) ? 32'(i) : 32'd7);
      check_val("sat.chg_exp", 32'(changed3), 32'd1);
      check_val("sat.q0_exp", 32'(q3[0]), 32'(i % 2));
    end

    // Reset in the middle of a cycle with live state
    do_reset();
    en = 1'b1; mode = 2'd1; a = 8'h01; b = 8'h00;
    for (int i = 0; i < 4; i++) step("pre_mid");
    mode = 2'd3; a = 8'h03; b = 8'h01; step("pre_mid_sr");
    check_val("pre_mid.count_exp", 32'(change_count), 32'd5);
    check_val("pre_mid.err_exp", 32'(sr_error), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    step("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
